// File: rtl/vliw_bundle_packer.sv
// Packs an in-order stream of 32-bit scalar instructions into 128-bit four-slot VLIW bundles
// {slot1, slot2, slot3, slot4}; the producer marks group boundaries with s_last.
module vliw_bundle_packer #(
  parameter logic [31:0] NOP = 32'h00000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_instr,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_bundle,
  output logic [3:0]   m_mask
);

  typedef enum logic [1:0] {StEmpty, StPart, StPend} state_e;
  typedef enum logic [1:0] {ClsMem, ClsAf, ClsBr, ClsC1} cls_e;

  function automatic cls_e decode(input logic [5:0] op);
    cls_e cls;
    if (op[5]) begin
      cls = ClsBr;
    end else begin
      case (op) inside
        6'h06, 6'h07, 6'h14, 6'h15:                               cls = ClsMem;
        [6'h00:6'h05], [6'h0b:6'h11], 6'h13, [6'h16:6'h18]:       cls = ClsAf;
        default:                                                  cls = ClsC1;
      endcase
    end
    return cls;
  endfunction

  // One-hot slot choice (bit3 = slot1); zero when the class has no free slot.
  function automatic logic [3:0] pick(input cls_e cls, input logic [3:0] mask);
    logic [3:0] sel;
    sel = 4'b0000;
    case (cls)
      ClsMem: begin
        if (!mask[1])      sel = 4'b0010;
        else if (!mask[0]) sel = 4'b0001;
      end
      ClsAf: begin
        if (!mask[2])      sel = 4'b0100;
        else if (!mask[3]) sel = 4'b1000;
      end
      default: begin
        if (!mask[3])      sel = 4'b1000;
      end
    endcase
    return sel;
  endfunction

  state_e           state_q, state_d;
  logic [3:0][31:0] acc_slots_q, acc_slots_d;
  logic [3:0]       acc_mask_q, acc_mask_d;

  cls_e             cls;
  logic [3:0]       sel_acc, sel_new, merged_mask;
  logic [3:0][31:0] merged_slots, fresh_slots;
  logic             fits, is_br, closes_merged, closes_fresh, out_free, accept;
  logic             emit;
  logic [3:0][31:0] emit_slots;
  logic [3:0]       emit_mask;

  always_comb begin
    cls     = decode(s_instr[31:26]);
    is_br   = (cls == ClsBr);
    sel_acc = pick(cls, acc_mask_q);
    sel_new = pick(cls, 4'b0000);
    fits    = |sel_acc;
    for (int i = 0; i < 4; i++) begin
      merged_slots[i] = sel_acc[i] ? s_instr : acc_slots_q[i];
      fresh_slots[i]  = sel_new[i] ? s_instr : NOP;
    end
    merged_mask   = acc_mask_q | sel_acc;
    closes_merged = is_br | s_last | (&merged_mask);
    closes_fresh  = is_br | s_last;
    out_free      = !m_valid | m_ready;
    // A non-fitting instruction forces an emit, so it needs the output register free.
    s_ready       = !rst & (state_q != StPend) & (fits | out_free);
    accept        = s_valid & s_ready;
  end

  always_comb begin
    state_d     = state_q;
    acc_slots_d = acc_slots_q;
    acc_mask_d  = acc_mask_q;
    emit        = 1'b0;
    emit_slots  = acc_slots_q;
    emit_mask   = acc_mask_q;
    case (state_q)
      StEmpty, StPart: begin
        if (accept) begin
          if (fits) begin
            if (closes_merged && out_free) begin
              emit        = 1'b1;
              emit_slots  = merged_slots;
              emit_mask   = merged_mask;
              acc_slots_d = {4{NOP}};
              acc_mask_d  = 4'b0000;
              state_d     = StEmpty;
            end else begin
              acc_slots_d = merged_slots;
              acc_mask_d  = merged_mask;
              state_d     = closes_merged ? StPend : StPart;
            end
          end else begin
            emit        = 1'b1;
            acc_slots_d = fresh_slots;
            acc_mask_d  = sel_new;
            state_d     = closes_fresh ? StPend : StPart;
          end
        end
      end
      StPend: begin
        if (out_free) begin
          emit        = 1'b1;
          acc_slots_d = {4{NOP}};
          acc_mask_d  = 4'b0000;
          state_d     = StEmpty;
        end
      end
      default: begin
        acc_slots_d = {4{NOP}};
        acc_mask_d  = 4'b0000;
        state_d     = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      acc_slots_q <= {4{NOP}};
      acc_mask_q  <= 4'b0000;
      m_valid     <= 1'b0;
      m_bundle    <= '0;
      m_mask      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      acc_slots_q <= acc_slots_d;
      acc_mask_q  <= acc_mask_d;
      if (emit) begin
        m_valid  <= 1'b1;
        m_bundle <= emit_slots;
        m_mask   <= emit_mask;
      end else if (m_ready) begin
        m_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Directed bench for vliw_bundle_packer: expected bundles go into a queue as stimulus is
// issued; a negedge monitor pops and compares on every output handshake.
module tb_vliw_bundle_packer;

  localparam logic [31:0] NP   = 32'h1300_00aa;
  localparam logic [31:0] ADDI = {6'h0c, 26'h0000101};
  localparam logic [31:0] FADD = {6'h0d, 26'h0000202};
  localparam logic [31:0] LW1  = {6'h06, 26'h0000303};
  localparam logic [31:0] LW2  = {6'h06, 26'h0000404};
  localparam logic [31:0] LW3  = {6'h06, 26'h0000505};
  localparam logic [31:0] LW4  = {6'h06, 26'h0000a0a};
  localparam logic [31:0] SW1  = {6'h07, 26'h0000606};
  localparam logic [31:0] SW2  = {6'h07, 26'h0000616};
  localparam logic [31:0] BEQ1 = {6'h24, 26'h0000707};
  localparam logic [31:0] BEQ2 = {6'h24, 26'h0000808};
  localparam logic [31:0] BEQA = {6'h24, 26'h0000b0b};
  localparam logic [31:0] BEQB = {6'h24, 26'h0000c0c};
  localparam logic [31:0] BEQC = {6'h24, 26'h0000d0d};
  localparam logic [31:0] BEQD = {6'h24, 26'h0000e0e};
  localparam logic [31:0] OUTI = {6'h0a, 26'h0000909};

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready, s_last, m_valid, m_ready;
  logic [31:0]  s_instr;
  logic [127:0] m_bundle;
  logic [3:0]   m_mask;

  typedef struct packed {
    logic [127:0] b;
    logic [3:0]   m;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  vliw_bundle_packer #(.NOP(NP)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_instr  (s_instr),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_bundle (m_bundle),
    .m_mask   (m_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic expect_b(input logic [127:0] b, input logic [3:0] m);
    q.push_back({b, m});
  endtask

  task automatic send(input logic [31:0] instr, input logic last);
    bit ok;
    int n;
    s_valid = 1'b1;
    s_instr = instr;
    s_last  = last;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: instr %h not accepted in 20 cycles", instr);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && m_valid && m_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_bundle: got %h mask %b want none", m_bundle, m_mask);
      end else begin
        e = q.pop_front();
        check("bundle", m_bundle, e.b);
        check("mask", {124'b0, m_mask}, {124'b0, e.m});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; s_valid = 1'b0; s_instr = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_mask", m_mask, 0);
    check("rst_m_bundle", m_bundle, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", s_ready, 1);

    // 1: full bundle closed by s_last
    expect_b({FADD, ADDI, LW1, SW1}, 4'b1111);
    send(ADDI, 0); send(FADD, 0); send(LW1, 0); send(SW1, 1);
    check("t1_latency", m_valid, 1);

    // 2: third load overflows the memory slots
    expect_b({NP, NP, LW1, LW2}, 4'b0011);
    send(LW1, 0); send(LW2, 0);
    check("t2_no_early_emit", m_valid, 0);
    send(LW3, 0);
    check("t2_overflow_emit", m_valid, 1);
    expect_b({NP, NP, LW3, SW2}, 4'b0011);
    send(SW2, 1);

    // 3: branch closes the bundle
    expect_b({BEQ1, ADDI, NP, NP}, 4'b1100);
    expect_b({BEQ2, NP, NP, NP}, 4'b1000);
    send(ADDI, 0); send(BEQ1, 0);
    check("t3_latency", m_valid, 1);
    send(BEQ2, 0);

    // 4: backpressure into PEND
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b0;
    expect_b({BEQA, NP, NP, NP}, 4'b1000);
    expect_b({BEQB, NP, NP, NP}, 4'b1000);
    send(BEQA, 0); send(BEQB, 0);
    check("t4_pend_s_ready", s_ready, 0);
    check("t4_hold", m_bundle, {BEQA, NP, NP, NP});
    repeat (2) @(posedge clk);
    #1;
    check("t4_pend_s_ready_2", s_ready, 0);
    check("t4_hold_2", m_bundle, {BEQA, NP, NP, NP});
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_pend_out", m_bundle, {BEQB, NP, NP, NP});
    check("t4_s_ready_back", s_ready, 1);

    // 5: branch cannot share slot1 with out
    expect_b({OUTI, NP, NP, NP}, 4'b1000);
    expect_b({BEQC, NP, NP, NP}, 4'b1000);
    send(OUTI, 0); send(BEQC, 0);
    check("t5_pend_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    check("t5_pend_emit", m_valid, 1);
    check("t5_s_ready_back", s_ready, 1);

    // 6: reset drops held and partial bundles
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    send(BEQD, 0); send(ADDI, 0);
    check("t6_held", m_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_m_valid", m_valid, 0);
    check("t6_rst_m_mask", m_mask, 0);
    check("t6_rst_m_bundle", m_bundle, 0);
    check("t6_rst_s_ready", s_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_post_rst_s_ready", s_ready, 1);
    m_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (m_valid) seen = 1'b1;
    end
    check("t6_no_stale_emit", seen, 0);
    expect_b({NP, NP, LW4, NP}, 4'b0010);
    send(LW4, 1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
